banc_registres: RTL and testbench
=================================

// Module: banc_registres
// PURPOSE
//  16 x 16-bit register file with pending-write scoreboard; sits directly upstream of the ALU.
//  QA/QB drive ALU inputs A/B.
//  Decode/issue logic reserves a destination on ISSUE.
//  Writeback stage returns the ALU result S on W/addrW/DATA.
//  STALL flags a read-after-write hazard or scoreboard overflow to the issue logic.
// PARAMETERS
//  NB_REG  16  number of registers (2**ADDR_W)
//  ADDR_W  4   register address width
//  DATA_W  16  data width, matches ALU operand width
// PORTS
//  CLK    in   1       clock, rising edge
//  RST    in   1       asynchronous reset, active high
//  addrA  in   ADDR_W  read port A address
//  addrB  in   ADDR_W  read port B address
//  useA   in   1       current instruction reads port A
//  useB   in   1       current instruction reads port B
//  QA     out  DATA_W  read data A (to ALU A)
//  QB     out  DATA_W  read data B (to ALU B)
//  ISSUE  in   1       instruction dispatched; reserves addrI
//  addrI  in   ADDR_W  destination register of the issued instruction
//  W      in   1       writeback enable
//  addrW  in   ADDR_W  writeback address
//  DATA   in   DATA_W  writeback data (ALU result S)
//  STALL  out  1       issue refused this cycle
// BEHAVIOUR
//  Interface: one clock CLK; RST asynchronous, active high.
//  Reset: all regs = 0 and all pending counters = 0. Outputs follow from that: QA = QB = 0, STALL = 0.
//   RST asserted mid-operation clears everything immediately; in-flight writebacks are lost.
//  Write: on CLK rise, if W, regs[addrW] <= DATA.
//  Read: combinational.
//   QA = (W && addrW==addrA) ? DATA : regs[addrA]. This is a same-cycle bypass, zero latency.
//   QB is identical on port B.
//  Scoreboard: per-register 2-bit pending counter cnt[r], range 0..3.
//   inc = ISSUE && !STALL, applied to addrI.
//   dec = W && cnt[addrW] != 0, applied to addrW.
//   A W to a register with cnt = 0 writes data and leaves cnt at 0. No underflow.
//   inc and dec on the same register in the same cycle: cnt unchanged.
//  STALL (combinational) = hazA | hazB | full.
//   hazA = useA && cnt[addrA] != 0 && !(W && addrW==addrA && cnt[addrA]==1).
//    The last pending write landing this cycle resolves the hazard through the bypass.
//   hazB is the same for port B.
//   full = ISSUE && cnt[addrI]==3 && !(W && addrW==addrI).
//  When STALL = 1, the issue is not accepted and no counter increments. Issue logic re-presents it next cycle.
//  STALL may assert with ISSUE = 0; it is meaningful only when ISSUE = 1.
// CONFIGURATION
//  R0_ZERO_EN defined:
//   - register 0 is hardwired to 0: QA/QB read 0 for address 0, with no bypass.
//   - writes to R0 are ignored.
//   - cnt[0] stays 0, and R0 never causes STALL.
//  R0_ZERO_EN undefined: R0 is an ordinary register.
// TESTING
//  1 Reset: pulse RST async between edges -> QA=QB=0x0000 and STALL=0 immediately; all cnt=0.
//  2 Write/bypass:
//    - W=1, addrW=3, DATA=0x1234, then addrA=3 next cycle -> QA=0x1234.
//    - W=1, addrW=5, DATA=0xBEEF with addrB=5 in the same cycle -> QB=0xBEEF combinationally.
//  3 RAW hazard:
//    - ISSUE, addrI=2 accepted.
//    - Next cycle: useA=1, addrA=2, W=0 -> STALL=1.
//    - Then W=1, addrW=2, DATA=0x00AA -> STALL=0, QA=0x00AA; after the edge cnt[2]=0.
//  4 Overflow: 3 accepted issues to R7 with no W -> 4th ISSUE to R7 gives STALL=1 and cnt[7] stays 3.
//    Same 4th issue with W=1, addrW=7 -> accepted, cnt[7] stays 3.
//  5 Spurious writeback and simultaneous inc/dec:
//    - W to R9 with cnt[9]=0 -> regs[9] updated, cnt[9]=0.
//    - ISSUE+W on R4 with cnt[4]=1 -> cnt[4]=1.
//  6 R0_ZERO_EN: W=1, addrW=0, DATA=0xFFFF; addrA=0 -> QA=0x0000.
//    ISSUE addrI=0, then useA on R0 -> STALL=0.
//    Undefined build: QA=0xFFFF and STALL=1.

Source files
------------

// File: rtl/banc_registres.sv
// Register file with zero-latency writeback bypass and per-register pending-write scoreboard.
// Build option: define R0_ZERO_EN to hardwire register 0 to zero.
module banc_registres #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int NB_REG = 2**ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [ADDR_W-1:0] addrB,
  input  logic              useA,
  input  logic              useB,
  output logic [DATA_W-1:0] QA,
  output logic [DATA_W-1:0] QB,
  input  logic              ISSUE,
  input  logic [ADDR_W-1:0] addrI,
  input  logic              W,
  input  logic [ADDR_W-1:0] addrW,
  input  logic [DATA_W-1:0] DATA,
  output logic              STALL
);

`ifdef R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [DATA_W-1:0] regs [NB_REG];
  logic [1:0]        cnt  [NB_REG];

  logic haz_a, haz_b, full, inc, dec, wr_en;

  // A hazard clears when the last pending write lands this cycle: the bypass supplies the value.
  always_comb begin
    haz_a = useA && (cnt[addrA] != 2'd0) && !(W && (addrW == addrA) && (cnt[addrA] == 2'd1));
    haz_b = useB && (cnt[addrB] != 2'd0) && !(W && (addrW == addrB) && (cnt[addrB] == 2'd1));
    full  = ISSUE && (cnt[addrI] == 2'd3) && !(W && (addrW == addrI));
    STALL = haz_a | haz_b | full;
    inc   = ISSUE && !STALL && !(R0_ZERO && (addrI == '0));
    dec   = W && (cnt[addrW] != 2'd0);
    wr_en = W && !(R0_ZERO && (addrW == '0));
  end

  always_comb begin
    if (R0_ZERO && (addrA == '0))    QA = '0;
    else if (W && (addrW == addrA))  QA = DATA;
    else                             QA = regs[addrA];
  end

  always_comb begin
    if (R0_ZERO && (addrB == '0))    QB = '0;
    else if (W && (addrW == addrB))  QB = DATA;
    else                             QB = regs[addrB];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NB_REG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      if (wr_en) regs[addrW] <= DATA;
      for (int r = 0; r < NB_REG; r++) begin
        if (inc && (addrI == ADDR_W'(r)) && !(dec && (addrW == ADDR_W'(r))))
          cnt[r] <= cnt[r] + 2'd1;
        else if (dec && (addrW == ADDR_W'(r)) && !(inc && (addrI == ADDR_W'(r))))
          cnt[r] <= cnt[r] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_banc_registres.sv
// Scoreboard bench for banc_registres: directed scenarios plus randomized traffic against a behavioural model.
module tb_banc_registres;

  logic        CLK, RST;
  logic [3:0]  addrA, addrB, addrI, addrW;
  logic        useA, useB, ISSUE, W;
  logic [15:0] DATA, QA, QB;
  logic        STALL;

  banc_registres dut (
    .CLK(CLK), .RST(RST), .addrA(addrA), .addrB(addrB), .useA(useA), .useB(useB),
    .QA(QA), .QB(QB), .ISSUE(ISSUE), .addrI(addrI), .W(W), .addrW(addrW),
    .DATA(DATA), .STALL(STALL)
  );

`ifdef R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  typedef struct {
    logic [15:0] qa;
    logic [15:0] qb;
    logic        st;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_regs [16];
  int          m_cnt  [16];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("QA", QA, e.qa);
      check("QB", QB, e.qb);
      check("STALL", {15'd0, STALL}, {15'd0, e.st});
    end
  end

  task automatic model_clear();
    for (int r = 0; r < 16; r++) begin
      m_regs[r] = 16'h0;
      m_cnt[r]  = 0;
    end
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] a, input logic w,
                                             input logic [3:0] aw, input logic [15:0] d);
    if (R0Z && a == 4'd0) return 16'h0;
    if (w && aw == a)     return d;
    return m_regs[a];
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, then advance the model past the next edge.
  task automatic drive(input logic [3:0] a_a, input logic [3:0] a_b, input logic u_a, input logic u_b,
                       input logic iss, input logic [3:0] a_i,
                       input logic w_e, input logic [3:0] a_w, input logic [15:0] d);
    exp_t e;
    bit   haz_a, haz_b, full, dec_ok;
    @(posedge CLK);
    #1;
    addrA = a_a; addrB = a_b; useA = u_a; useB = u_b;
    ISSUE = iss; addrI = a_i; W = w_e; addrW = a_w; DATA = d;
    haz_a = u_a && m_cnt[a_a] > 0 && !(w_e && a_w == a_a && m_cnt[a_a] == 1);
    haz_b = u_b && m_cnt[a_b] > 0 && !(w_e && a_w == a_b && m_cnt[a_b] == 1);
    full  = iss && m_cnt[a_i] == 3 && !(w_e && a_w == a_i);
    e.qa = model_read(a_a, w_e, a_w, d);
    e.qb = model_read(a_b, w_e, a_w, d);
    e.st = haz_a || haz_b || full;
    sb.push_back(e);
    dec_ok = w_e && m_cnt[a_w] > 0;
    if (w_e && !(R0Z && a_w == 4'd0)) m_regs[a_w] = d;
    if (iss && !e.st && !(R0Z && a_i == 4'd0)) m_cnt[a_i] = m_cnt[a_i] + 1;
    if (dec_ok) m_cnt[a_w] = m_cnt[a_w] - 1;
  endtask

  task automatic idle();
    drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
  endtask

  // Asynchronous reset pulse placed between edges, after the monitor has consumed the queue.
  task automatic pulse_reset();
    @(negedge CLK);
    #1;
    useA = 0; useB = 0; ISSUE = 0; W = 0;
    RST = 1'b1;
    #1;
    check("rst_QA", QA, 16'h0);
    check("rst_QB", QB, 16'h0);
    check("rst_STALL", {15'd0, STALL}, 16'h0);
    RST = 1'b0;
    model_clear();
  endtask

  initial begin
    RST = 1'b1; addrA = 0; addrB = 0; useA = 0; useB = 0;
    ISSUE = 0; addrI = 0; W = 0; addrW = 0; DATA = 0;
    model_clear();
    #2;
    check("init_QA", QA, 16'h0);
    check("init_QB", QB, 16'h0);
    check("init_STALL", {15'd0, STALL}, 16'h0);
    #1 RST = 1'b0;

    // write then read, and same-cycle bypass on port B
    drive(4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 4'd3, 16'h1234);
    drive(4'd3, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 16'h0);
    drive(4'd3, 4'd5, 0, 0, 0, 4'd0, 1, 4'd5, 16'hBEEF);
    drive(4'd5, 4'd3, 0, 0, 0, 4'd0, 0, 4'd0, 16'h0);

    // RAW hazard resolved by the landing writeback
    drive(4'd0, 4'd0, 0, 0, 1, 4'd2, 0, 4'd0, 16'h0);
    drive(4'd2, 4'd0, 1, 0, 0, 4'd0, 0, 4'd0, 16'h0);
    drive(4'd2, 4'd0, 1, 0, 0, 4'd0, 1, 4'd2, 16'h00AA);
    drive(4'd2, 4'd2, 1, 1, 0, 4'd0, 0, 4'd0, 16'h0);

    // scoreboard saturation on R7
    repeat (3) drive(4'd0, 4'd0, 0, 0, 1, 4'd7, 0, 4'd0, 16'h0);
    drive(4'd0, 4'd0, 0, 0, 1, 4'd7, 0, 4'd0, 16'h0);
    drive(4'd0, 4'd0, 0, 0, 1, 4'd7, 1, 4'd7, 16'h7777);
    drive(4'd0, 4'd0, 0, 0, 1, 4'd7, 0, 4'd0, 16'h0);

    // spurious writeback, then simultaneous inc/dec on R4
    drive(4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 4'd9, 16'h5A5A);
    drive(4'd9, 4'd0, 1, 0, 0, 4'd0, 0, 4'd0, 16'h0);
    drive(4'd0, 4'd0, 0, 0, 1, 4'd4, 0, 4'd0, 16'h0);
    drive(4'd0, 4'd0, 0, 0, 1, 4'd4, 1, 4'd4, 16'h4444);
    drive(4'd4, 4'd0, 1, 0, 0, 4'd0, 0, 4'd0, 16'h0);
    drive(4'd4, 4'd0, 1, 0, 0, 4'd0, 1, 4'd4, 16'h4545);
    drive(4'd4, 4'd0, 1, 0, 0, 4'd0, 0, 4'd0, 16'h0);

    // register 0 behaviour (build dependent)
    drive(4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 4'd0, 16'hFFFF);
    drive(4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 16'h0);
    drive(4'd0, 4'd0, 0, 0, 1, 4'd0, 0, 4'd0, 16'h0);
    drive(4'd0, 4'd0, 1, 0, 0, 4'd0, 0, 4'd0, 16'h0);

    pulse_reset();
    drive(4'd3, 4'd7, 1, 1, 1, 4'd7, 0, 4'd0, 16'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] ra, rb, ri, rw;
      bool_narrow : begin end
      ra = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      ri = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      rw = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      drive(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 5), ri, ($urandom_range(0, 9) < 4), rw, 16'($urandom));
      if (i % 700 == 699) pulse_reset();
    end

    idle();
    repeat (3) @(posedge CLK);
    check("sb_drained", 16'(sb.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
